// File: rtl/fp_divsqrt_sched_pkg.sv
// fp_pkg: opcode/funct7 constants, scheduler state and op-select encodings
package fp_pkg;
  localparam logic [6:0] OPCODE_FP       = 7'b1010011;
  localparam logic [6:0] OPCODE_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPCODE_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPCODE_FMADD    = 7'b1000011;
  localparam logic [6:0] OPCODE_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPCODE_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPCODE_FNMADD   = 7'b1001111;
  localparam logic [6:0] FP_ADD          = 7'b0000000;
  localparam logic [6:0] FP_SUB          = 7'b0000100;
  localparam logic [6:0] FP_MUL          = 7'b0001000;
  localparam logic [6:0] FP_DIV          = 7'b0001100;
  localparam logic [6:0] FP_SQRT         = 7'b0101100;
  localparam logic [6:0] FP_SGNJ         = 7'b0010000;
  localparam logic [6:0] FP_MINMAX       = 7'b0010100;
  localparam logic [6:0] FP_CMP          = 7'b1010000;
  localparam logic [6:0] FP_CVT_W_S      = 7'b1100000;
  localparam logic [6:0] FP_CVT_S_W      = 7'b1101000;
  localparam logic [6:0] FP_MV_X_W       = 7'b1110000;
  localparam logic [6:0] FP_MV_W_X       = 7'b1111000;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_WB = 2'd2} state_e;
  typedef enum logic {OP_DIV = 1'b0, OP_SQRT = 1'b1} op_e;
endpackage

// File: rtl/fp_divsqrt_sched_if.sv
// fp_divsqrt_sched_if: issue, unit, writeback and decode-hazard signals of the div/sqrt scheduler
interface fp_divsqrt_sched_if;
  logic       i_issue_valid;
  logic [6:0] i_issue_funct7;
  logic [4:0] i_issue_rd;
  logic       i_flush;
  logic       o_issue_ready;
  logic       o_illegal;
  logic       o_unit_start;
  logic       o_unit_op;
  logic       i_wb_slot_free;
  logic       o_wb_valid;
  logic [4:0] o_wb_rd;
  logic [6:0] i_dec_opcode;
  logic [6:0] i_dec_funct7;
  logic [4:0] i_dec_rs1;
  logic [4:0] i_dec_rs2;
  logic [4:0] i_dec_rs3;
  logic [4:0] i_dec_rd;
  logic       o_hazard_stall;
  logic       o_busy;
  modport master (
    output i_issue_valid, i_issue_funct7, i_issue_rd, i_flush, i_wb_slot_free,
    output i_dec_opcode, i_dec_funct7, i_dec_rs1, i_dec_rs2, i_dec_rs3, i_dec_rd,
    input  o_issue_ready, o_illegal, o_unit_start, o_unit_op, o_wb_valid, o_wb_rd,
    input  o_hazard_stall, o_busy
  );
  modport slave (
    input  i_issue_valid, i_issue_funct7, i_issue_rd, i_flush, i_wb_slot_free,
    input  i_dec_opcode, i_dec_funct7, i_dec_rs1, i_dec_rs2, i_dec_rs3, i_dec_rd,
    output o_issue_ready, o_illegal, o_unit_start, o_unit_op, o_wb_valid, o_wb_rd,
    output o_hazard_stall, o_busy
  );
endinterface

// File: rtl/fp_divsqrt_sched_src_decode.sv
// fp_src_decode: which FP registers an instruction reads and whether it writes the FP file
module fp_src_decode
  import fp_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       uses_rs3,
  output logic       writes_fp_rd
);
  logic r4, fp;
  assign r4 = opcode inside {OPCODE_FMADD, OPCODE_FMSUB, OPCODE_FNMSUB, OPCODE_FNMADD};
  assign fp = opcode == OPCODE_FP;
  assign uses_rs1 = r4 | fp & ~(funct7 inside {FP_CVT_S_W, FP_MV_W_X});
  assign uses_rs2 = r4 | opcode == OPCODE_STORE_FP
                  | fp & (funct7 inside {FP_ADD, FP_SUB, FP_MUL, FP_DIV, FP_SGNJ, FP_MINMAX, FP_CMP});
  assign uses_rs3 = r4;
  assign writes_fp_rd = r4 | opcode == OPCODE_LOAD_FP
                      | fp & ~(funct7 inside {FP_CVT_W_S, FP_MV_X_W, FP_CMP});
endmodule

// File: rtl/fp_divsqrt_sched.sv
// fp_divsqrt_sched: issues FDIV/FSQRT to the shared unit, times it, claims WB, stalls decode on hazards (sqrt gated by FP_SQRT_EN)
module fp_divsqrt_sched
  import fp_pkg::*;
#(
  parameter int DIV_LAT  = 12,
  parameter int SQRT_LAT = 14
) (
  input logic i_clk,
  input logic i_rst,
  fp_divsqrt_sched_if.slave bus
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] BUSY = ST_BUSY;
  localparam logic [1:0] WB   = ST_WB;
  localparam int CW = $clog2(DIV_LAT > SQRT_LAT ? DIV_LAT : SQRT_LAT);
  logic [1:0] state;
  logic [CW-1:0] cnt, lat;
  logic start, illegal, op, ready, acc, is_div, is_sqrt, go, bad, wb, pend, hit, dd;
  logic [4:0] rd;
  logic u1, u2, u3, wr;
  assign ready = state == IDLE & ~i_rst;
  assign acc = bus.i_issue_valid & ready & ~bus.i_flush;
  assign is_div = bus.i_issue_funct7 == FP_DIV;
  assign is_sqrt = bus.i_issue_funct7 == FP_SQRT;
`ifdef FP_SQRT_EN
  assign go = acc & (is_div | is_sqrt);
  assign bad = 1'b0;
  assign lat = is_sqrt ? CW'(SQRT_LAT - 1) : CW'(DIV_LAT - 1);
`else
  assign go = acc & is_div;
  assign bad = acc & is_sqrt;
  assign lat = CW'(DIV_LAT - 1);
`endif
  // accept, count down the unit latency, then hold in WB until the slot is free
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      start <= 1'b0;
      illegal <= 1'b0;
      op <= OP_DIV;
      rd <= '0;
    end else begin
      start <= go;
      illegal <= bad;
      if (go) begin
        state <= BUSY;
        cnt <= lat;
        rd <= bus.i_issue_rd;
        op <= is_sqrt;
      end else if (state == BUSY) begin
        if (cnt == '0) state <= WB;
        else cnt <= cnt - 1'b1;
      end else if (state == WB && wb) state <= IDLE;
    end
  end
  fp_src_decode u_dec (
    .opcode(bus.i_dec_opcode), .funct7(bus.i_dec_funct7),
    .uses_rs1(u1), .uses_rs2(u2), .uses_rs3(u3), .writes_fp_rd(wr)
  );
  assign wb = state == WB & bus.i_wb_slot_free;
  assign pend = state == BUSY | state == WB & ~wb;
  assign hit = u1 & bus.i_dec_rs1 == rd | u2 & bus.i_dec_rs2 == rd
             | u3 & bus.i_dec_rs3 == rd | wr & bus.i_dec_rd == rd;
  assign dd = bus.i_dec_opcode == OPCODE_FP & (bus.i_dec_funct7 == FP_DIV | bus.i_dec_funct7 == FP_SQRT);
  assign bus.o_hazard_stall = pend & (hit | dd);
  assign bus.o_issue_ready = ready;
  assign bus.o_illegal = illegal;
  assign bus.o_unit_start = start;
  assign bus.o_unit_op = op;
  assign bus.o_wb_valid = wb;
  assign bus.o_wb_rd = rd;
  assign bus.o_busy = state != IDLE;
endmodule

// File: tb/tb_fp_divsqrt_sched.sv
// tb_fp_divsqrt_sched: random issue/decode/slot traffic checked against a transaction-level model
module tb_fp_divsqrt_sched;
  localparam int DL = 12;
  localparam int SL = 14;
`ifdef FP_SQRT_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif
  localparam logic [6:0] FDIV = 7'b0001100;
  localparam logic [6:0] FSQRT = 7'b0101100;
  typedef struct {
    logic [6:0] opc;
    logic [6:0] f7;
    bit u1, u2, u3, w, sd;
  } ins_t;
  ins_t tbl[16];
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  fp_divsqrt_sched_if bus();
  fp_divsqrt_sched #(.DIV_LAT(DL), .SQRT_LAT(SL)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  initial begin
    bit pend, wbv, hit, acc, e_ill, pop;
    int rdy_at, st_at, j, k;
    logic [4:0] prd;
    logic [6:0] f7;
    tbl[0]  = '{7'b1010011, 7'b0000000, 1, 1, 0, 1, 0};
    tbl[1]  = '{7'b1010011, 7'b0000100, 1, 1, 0, 1, 0};
    tbl[2]  = '{7'b1010011, 7'b0001000, 1, 1, 0, 1, 0};
    tbl[3]  = '{7'b1010011, 7'b0001100, 1, 1, 0, 1, 1};
    tbl[4]  = '{7'b1010011, 7'b0101100, 1, 0, 0, 1, 1};
    tbl[5]  = '{7'b1010011, 7'b0010000, 1, 1, 0, 1, 0};
    tbl[6]  = '{7'b1010011, 7'b0010100, 1, 1, 0, 1, 0};
    tbl[7]  = '{7'b1010011, 7'b1010000, 1, 1, 0, 0, 0};
    tbl[8]  = '{7'b1010011, 7'b1100000, 1, 0, 0, 0, 0};
    tbl[9]  = '{7'b1010011, 7'b1101000, 0, 0, 0, 1, 0};
    tbl[10] = '{7'b1010011, 7'b1110000, 1, 0, 0, 0, 0};
    tbl[11] = '{7'b1010011, 7'b1111000, 0, 0, 0, 1, 0};
    tbl[12] = '{7'b0000111, 7'b0000000, 0, 0, 0, 1, 0};
    tbl[13] = '{7'b0100111, 7'b0000000, 0, 1, 0, 0, 0};
    tbl[14] = '{7'b1000011, 7'b0000000, 1, 1, 1, 1, 0};
    tbl[15] = '{7'b0110011, 7'b0000000, 0, 0, 0, 0, 0};
    bus.i_issue_valid = 1'b0;
    bus.i_issue_funct7 = '0;
    bus.i_issue_rd = '0;
    bus.i_flush = 1'b0;
    bus.i_wb_slot_free = 1'b0;
    bus.i_dec_opcode = '0;
    bus.i_dec_funct7 = '0;
    bus.i_dec_rs1 = '0;
    bus.i_dec_rs2 = '0;
    bus.i_dec_rs3 = '0;
    bus.i_dec_rd = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_start", 32'(bus.o_unit_start), 0);
    chk("rst_wb_valid", 32'(bus.o_wb_valid), 0);
    chk("rst_illegal", 32'(bus.o_illegal), 0);
    chk("rst_stall", 32'(bus.o_hazard_stall), 0);
    chk("rst_wb_rd", 32'(bus.o_wb_rd), 0);
    chk("rst_op", 32'(bus.o_unit_op), 0);
    chk("rst_ready", 32'(bus.o_issue_ready), 0);
    pend = 0; e_ill = 0; pop = 0; prd = '0; rdy_at = 0; st_at = -1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      rst = c > 0 && $urandom_range(0, 299) == 0;
      bus.i_issue_valid = $urandom_range(0, 2) == 0;
      k = $urandom_range(0, 5);
      f7 = k < 2 ? FDIV : k < 4 ? FSQRT : k == 4 ? 7'b0000000 : 7'($urandom);
      bus.i_issue_funct7 = f7;
      bus.i_issue_rd = 5'($urandom_range(4, 8));
      bus.i_flush = $urandom_range(0, 5) == 0;
      bus.i_wb_slot_free = $urandom_range(0, 3) != 0;
      j = $urandom_range(0, 15);
      bus.i_dec_opcode = tbl[j].opc;
      bus.i_dec_funct7 = tbl[j].opc == 7'b0000111 ? 7'($urandom) : tbl[j].f7;
      bus.i_dec_rs1 = 5'($urandom_range(4, 8));
      bus.i_dec_rs2 = 5'($urandom_range(4, 8));
      bus.i_dec_rs3 = 5'($urandom_range(4, 8));
      bus.i_dec_rd = 5'($urandom_range(4, 8));
      #1;
      wbv = pend && c >= rdy_at && bus.i_wb_slot_free;
      hit = tbl[j].u1 && bus.i_dec_rs1 == prd || tbl[j].u2 && bus.i_dec_rs2 == prd
         || tbl[j].u3 && bus.i_dec_rs3 == prd || tbl[j].w && bus.i_dec_rd == prd;
      chk("ready", 32'(bus.o_issue_ready), 32'(!pend && !rst));
      chk("busy", 32'(bus.o_busy), 32'(pend));
      chk("start", 32'(bus.o_unit_start), 32'(c == st_at));
      chk("wb_valid", 32'(bus.o_wb_valid), 32'(wbv));
      chk("illegal", 32'(bus.o_illegal), 32'(e_ill));
      chk("stall", 32'(bus.o_hazard_stall), 32'(pend && !wbv && (hit || tbl[j].sd)));
      chk("wb_rd", 32'(bus.o_wb_rd), 32'(prd));
      chk("op", 32'(bus.o_unit_op), 32'(pop));
      acc = bus.i_issue_valid && !pend && !rst && !bus.i_flush && (f7 == FDIV || f7 == FSQRT && SQ);
      e_ill = bus.i_issue_valid && !pend && !rst && !bus.i_flush && f7 == FSQRT && !SQ;
      if (wbv) pend = 0;
      if (acc) begin
        pend = 1;
        prd = bus.i_issue_rd;
        pop = f7 == FSQRT;
        rdy_at = c + 1 + (pop ? SL : DL);
        st_at = c + 1;
      end
      if (rst) begin
        pend = 0; prd = '0; pop = 0; e_ill = 0; st_at = -1;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_divsqrt_sched.md
# fp_divsqrt_sched

Scheduler for the shared iterative FP divide/square-root unit. It accepts FDIV.S/FSQRT.S from the execute stage, starts the fixed-latency unit, and counts cycles to completion. It then claims the single FP writeback slot for the result. While the operation is outstanding, it stalls decode on RAW/WAW hazards against the pending destination register. It sits beside the FP forwarding logic: the result lands on the normal WB bus, so the forwarding logic covers the completion cycle.

## Interface
Parameters:
- DIV_LAT, 12, unit cycles from start to FDIV result valid (≥2)
- SQRT_LAT, 14, unit cycles from start to FSQRT result valid (≥2)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_issue_valid  in  1  EX-stage instruction with opcode OPCODE_FP
- i_issue_funct7  in  7  funct7 of the EX instruction
- i_issue_rd  in  5  destination of the EX instruction
- i_flush  in  1  EX instruction squashed this cycle
- o_issue_ready  out  1  scheduler can accept an issue
- o_illegal  out  1  one-cycle pulse: FSQRT issued with sqrt compiled out
- o_unit_start  out  1  one-cycle start pulse to the unit
- o_unit_op  out  1  0 = divide, 1 = sqrt; held stable from start through writeback
- i_wb_slot_free  in  1  pipeline WB stage is not writing the FP register file this cycle
- o_wb_valid  out  1  unit result is written to FP register o_wb_rd this cycle
- o_wb_rd  out  5  pending destination
- i_dec_opcode, i_dec_funct7  in  7,7  decode-stage instruction fields
- i_dec_rs1, i_dec_rs2, i_dec_rs3, i_dec_rd  in  5 each  decode-stage register fields
- o_hazard_stall  out  1  decode must hold
- o_busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, BUSY, WB.
- Accept condition: `i_issue_valid & o_issue_ready & ~i_flush`, with funct7 equal to FP_DIV or FP_SQRT. Other funct7 values are ignored.
- On accept: latch rd and op, then go to BUSY.
- The counter loads LAT−1 for the selected op.
- BUSY: the counter decrements each cycle. The state goes to WB when the counter reaches 0.
- WB: o_wb_valid = i_wb_slot_free. On o_wb_valid, go to IDLE. Otherwise, wait in WB with no timeout.
- o_issue_ready = (state == IDLE) & ~i_rst.
- There is no same-cycle WB→new-issue overlap.
- o_hazard_stall (combinational) is asserted when all three hold:
  - state is BUSY, or state is WB without o_wb_valid;
  - the decode instruction uses pending rd as an FP source (rs1, rs2 or rs3, decided by fp_src_decode), or writes pending rd to the FP register file (WAW);
  - or the decode instruction is itself FDIV/FSQRT, whichever of these last two applies.
- In the o_wb_valid cycle the stall drops, and forwarding supplies the value.
- FP source rules:
  - rs1 is an FP source for all FP/R4 ops except FLW, FSW, FCVT.S.W and FMV.W.X.
  - rs2 is an FP source for FSW, R4 ops, and FP ADD/SUB/MUL/DIV/SGNJ/MINMAX/COMP.
  - rs3 is an FP source for R4 ops only.
- A flush never affects an already-accepted operation; an accepted operation always completes.

## Timing
- Reset values: state IDLE, counter 0, o_unit_start 0, o_wb_valid 0, o_illegal 0, o_busy 0, o_hazard_stall 0, o_wb_rd 0, o_unit_op 0.
- Accept at cycle N gives o_unit_start high in N+1 only, and o_busy high from N+1.
- The first o_wb_valid opportunity is N+1+LAT, when i_wb_slot_free is high.
- The next accept is possible at the cycle after the o_wb_valid cycle.
- Reset asserted mid-operation: IDLE on the next edge, the result is discarded, and no o_wb_valid follows.

## Configuration
- FP_SQRT_EN defined: FSQRT is accepted with SQRT_LAT.
- FP_SQRT_EN undefined:
  - FSQRT accept instead pulses o_illegal in N+1; the state stays IDLE and no start is issued.
  - The sqrt latency logic and SQRT_LAT are unused.

## Structure
- Package fp_pkg holds:
  - OPCODE_* and FP_* funct7 constants;
  - the state enum (IDLE/BUSY/WB);
  - the op-select encoding.
- Sub-module fp_src_decode: opcode/funct7 → {uses_rs1, uses_rs2, uses_rs3, writes_fp_rd}. Forwarding reuses it.

## Test plan
- FDIV rd=5, slot always free: o_unit_start at N+1, o_wb_valid with rd=5 at N+13, o_issue_ready back at N+14.
- FSQRT, i_wb_slot_free low in cycles N+15..N+17: o_wb_valid at N+18, hazard stall held through N+17.
- Pending rd=7; decode FADD rs2=7 → stall. Decode FSW rs1=7 → no stall. Decode FMADD rs3=7 → stall. Decode FLW rd=7 → stall (WAW).
- Issue with i_flush=1 → no start, busy stays 0. Back-to-back FDIV decoded while busy → stalled until the WB cycle.
- i_rst at N+5 of an FDIV: all outputs 0 the next cycle, no o_wb_valid ever.
- FP_SQRT_EN undefined, FSQRT issue → o_illegal pulse at N+1, o_busy stays 0.
